// File: rtl/perm_out_ser.sv
// perm_out_ser: buffers 64-bit lane words in a small FIFO and serializes them
// as a framed byte stream. Each frame is a header byte (ctl=1) followed by
// 8 bytes per word, LSB first (ctl=0). Between frames the idle token
// (ctl=1, data=0) is driven. Words arriving without a frame start, or frame
// starts arriving mid-frame, raise a one-cycle frame_err pulse.
module perm_out_ser #(
    parameter int         DEPTH    = 4,
    parameter int         WORDS    = 25,
    parameter logic [7:0] RESP_HDR = 8'h04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pushin,
    input  logic        firstin,
    input  logic [63:0] din,
    output logic        stopin,
    output logic        out_ctl,
    output logic [7:0]  out_data,
    input  logic        out_stop,
    output logic        frame_err
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int WCW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    typedef struct packed {
        logic        first;
        logic [63:0] word;
    } entry_t;

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_d;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    entry_t        head;

    // A word is taken only while the registered full flag is low, so a
    // pop on a full cycle frees a slot that is refilled one edge later.
    assign push       = pushin && !stopin;
    assign fifo_empty = (count == '0);
    assign head       = mem[rd_ptr];

    // Next occupancy from this cycle's push/pop pair.
    // NOTE: combinational blocks assign every output a default first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        count_d = count;
        if (push && !pop) begin
            count_d = count + CW'(1);
        end else if (!push && pop) begin
            count_d = count - CW'(1);
        end
    end

    // Pointer, occupancy and registered full flag.
    // NOTE: state is updated with non-blocking assignments so every flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            stopin <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count  <= count_d;
            stopin <= (count_d == CW'(DEPTH));
        end
    end

    // Storage write; contents are only ever read behind a valid count.
    // NOTE: the storage array has no reset; clearing pointers and count is enough to make it empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{first: firstin, word: din};
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_t         state;
    state_t         state_d;
    logic [2:0]     byte_idx;
    logic [2:0]     byte_idx_d;
    logic [WCW-1:0] word_cnt;
    logic [WCW-1:0] word_cnt_d;
    logic [WCW-1:0] word_cnt_inc;
    logic [63:0]    shreg;
    logic [63:0]    shreg_d;
    logic           out_ctl_d;
    logic [7:0]     out_data_d;
    logic           frame_err_d;

    assign word_cnt_inc = (word_cnt == WCW'(WORDS - 1)) ? '0 : word_cnt + WCW'(1);

    // Next state, pop request and next output values; out_stop freezes all.
    always_comb begin
        state_d     = state;
        byte_idx_d  = byte_idx;
        word_cnt_d  = word_cnt;
        shreg_d     = shreg;
        out_ctl_d   = out_ctl;
        out_data_d  = out_data;
        frame_err_d = 1'b0;
        pop         = 1'b0;
        if (!out_stop) begin
            unique case (state)
                IDLE: begin
                    out_ctl_d  = 1'b1;
                    out_data_d = 8'h00;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shreg_d    = head.word;
                        byte_idx_d = 3'd0;
                        if (head.first) begin
                            // A frame start while a frame is open resyncs.
                            frame_err_d = (word_cnt != '0);
                            state_d     = HDR;
                        end else if (word_cnt != '0) begin
                            state_d = DATA;
                        end else begin
                            // Continuation word with no open frame: drop it.
                            frame_err_d = 1'b1;
                        end
                    end
                end
                HDR: begin
                    out_ctl_d  = 1'b1;
                    out_data_d = RESP_HDR;
                    word_cnt_d = '0;
                    state_d    = DATA;
                end
                DATA: begin
                    out_ctl_d  = 1'b0;
                    out_data_d = shreg[7:0];
                    shreg_d    = {8'h00, shreg[63:8]};
                    byte_idx_d = byte_idx + 3'd1;
                    if (byte_idx == 3'd7) begin
                        word_cnt_d = word_cnt_inc;
                        if (!fifo_empty) begin
                            // Chain the next word with no idle gap.
                            pop        = 1'b1;
                            shreg_d    = head.word;
                            byte_idx_d = 3'd0;
                            if (head.first) begin
                                frame_err_d = (word_cnt_inc != '0);
                                state_d     = HDR;
                            end else if (word_cnt_inc == '0) begin
                                frame_err_d = 1'b1;
                                state_d     = IDLE;
                            end
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM and output registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            byte_idx  <= 3'd0;
            word_cnt  <= '0;
            shreg     <= '0;
            out_ctl   <= 1'b1;
            out_data  <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            byte_idx  <= byte_idx_d;
            word_cnt  <= word_cnt_d;
            shreg     <= shreg_d;
            out_ctl   <= out_ctl_d;
            out_data  <= out_data_d;
            frame_err <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_perm_out_ser.sv
// Testbench for perm_out_ser: directed frames with a byte-stream reference
// model built from accepted words, plus literal spot checks.
module tb_perm_out_ser;

    localparam int          DEPTH    = 4;
    localparam int          WORDS    = 25;
    localparam logic [7:0]  RESP_HDR = 8'h04;
    localparam logic [63:0] STEP     = 64'h0101010101010101;

    bit          clk;
    logic        reset    = 1'b1;
    logic        pushin   = 1'b0;
    logic        firstin  = 1'b0;
    logic        out_stop = 1'b0;
    logic [63:0] din      = '0;
    logic        stopin;
    logic        out_ctl;
    logic [7:0]  out_data;
    logic        frame_err;

    perm_out_ser #(
        .DEPTH   (DEPTH),
        .WORDS   (WORDS),
        .RESP_HDR(RESP_HDR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pushin   (pushin),
        .firstin  (firstin),
        .din      (din),
        .stopin   (stopin),
        .out_ctl  (out_ctl),
        .out_data (out_data),
        .out_stop (out_stop),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic       edge_reset = 1'b1;
    logic       edge_stop  = 1'b0;
    logic [8:0] exp_q[$];
    int         m_cnt = 0;
    int         exp_err = 0;
    int         act_err = 0;
    int         run_len = 0;
    int         last_run = 0;
    int         data_bytes_seen = 0;
    int         hdr_count = 0;
    int         hdr_cyc = 0;
    int         first_acc_cyc = 0;
    int         sent_done = 0;
    int         err_base = 0;
    int         hdr_base = 0;
    logic [7:0] seen_data [256];
    logic       prev_ctl  = 1'b1;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expand one accepted word into its expected tokens.
    function automatic void model_accept(input logic first, input logic [63:0] w);
        if (first) begin
            if (m_cnt != 0) exp_err++;
            exp_q.push_back({1'b1, RESP_HDR});
            m_cnt = 0;
        end else if (m_cnt == 0) begin
            exp_err++;
            return;
        end
        for (int j = 0; j < 8; j++) exp_q.push_back({1'b0, w[8*j +: 8]});
        m_cnt = (m_cnt + 1) % WORDS;
    endfunction

    // Input monitor: record what the DUT takes at each edge.
    always @(posedge clk) begin
        cyc++;
        edge_reset = reset;
        edge_stop  = out_stop;
        if (reset) begin
            exp_q.delete();
            m_cnt = 0;
        end else if (pushin && !stopin) begin
            if (firstin) first_acc_cyc = cyc;
            model_accept(firstin, din);
        end
    end

    // Output compare, mid-cycle.
    always @(negedge clk) begin
        if (frame_err === 1'b1) act_err++;
        if (edge_reset) begin
            check("rst_ctl", out_ctl, 1'b1);
            check("rst_data", out_data, 8'h00);
            check("rst_stopin", stopin, 1'b0);
            check("rst_frame_err", frame_err, 1'b0);
            run_len = 0;
        end else if (edge_stop) begin
            check("hold_ctl", out_ctl, prev_ctl);
            check("hold_data", out_data, prev_data);
        end else if (out_ctl === 1'b1 && out_data === 8'h00) begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
        end else begin
            run_len++;
            check("stream_pending", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("stream_token", {out_ctl, out_data}, exp_q.pop_front());
            if (out_ctl) begin
                hdr_count++;
                hdr_cyc = cyc;
                data_bytes_seen = 0;
            end else begin
                if (data_bytes_seen < 256) seen_data[data_bytes_seen] = out_data;
                data_bytes_seen++;
            end
        end
        prev_ctl  = out_ctl;
        prev_data = out_data;
    end

    task automatic send_word(input logic first, input logic [63:0] w);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        pushin = 1'b1; firstin = first; din = w;
        while (!acc && n < 500) begin
            @(posedge clk);
            acc = !stopin && !reset;
            if (acc) sent_done++;
            n++;
        end
        #1;
        if (!acc) check("push_accept_timeout", acc, 1'b1);
    endtask

    task automatic send_frame(input int nwords, input logic [63:0] base);
        for (int k = 0; k < nwords; k++) send_word(k == 0, base + 64'(k) * STEP);
        pushin = 1'b0; firstin = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 4000) check({name, "_drain_timeout"}, exp_q.size(), 0);
        repeat (4) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_stopin", stopin, 1'b0);
        check("reset_ctl", out_ctl, 1'b1);
        check("reset_data", out_data, 8'h00);
        check("reset_frame_err", frame_err, 1'b0);
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Orphan continuation word after reset
        last_run = 0; err_base = act_err;
        send_word(1'b0, 64'hDEAD_BEEF_0000_0001);
        pushin = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        check("orphan_err_pulses", act_err - err_base, 1);
        check("orphan_no_output", last_run + run_len, 0);
        check("orphan_idle_ctl", out_ctl, 1'b1);
        check("orphan_idle_data", out_data, 8'h00);

        // Single full frame
        last_run = 0; hdr_base = hdr_count;
        send_frame(WORDS, 64'h0);
        drain("frame");
        check("frame_hdr_latency", hdr_cyc - first_acc_cyc, 2);
        check("frame_run_len", last_run, 201);
        check("frame_hdrs", hdr_count - hdr_base, 1);
        check("frame_bytes", data_bytes_seen, 200);
        check("frame_byte0", seen_data[0], 8'h00);
        check("frame_byte29", seen_data[29], 8'h03);
        check("frame_byte199", seen_data[199], 8'h18);
        check("frame_tail_ctl", out_ctl, 1'b1);
        check("frame_tail_data", out_data, 8'h00);

        // Back-pressure mid word 3 with continuous pushing
        last_run = 0; hdr_base = hdr_count; sent_done = 0;
        fork
            send_frame(WORDS, 64'h0);
            begin : bp_ctl
                int n;
                n = 0;
                while (!(hdr_count > hdr_base && data_bytes_seen >= 26) && n < 1000) begin
                    @(posedge clk); #1; n++;
                end
                check("bp_reach_word3", n < 1000, 1'b1);
                out_stop = 1'b1;
                repeat (10) begin @(posedge clk); #1; end
                check("bp_stopin_full", stopin, 1'b1);
                check("bp_frozen_bytes", data_bytes_seen, 27);
                check("bp_buffered_words", sent_done - (data_bytes_seen + 7) / 8, DEPTH);
                out_stop = 1'b0;
            end
        join
        drain("bp");
        check("bp_run_len", last_run, 201);
        check("bp_bytes", data_bytes_seen, 200);
        check("bp_byte27", seen_data[27], 8'h03);
        check("bp_byte199", seen_data[199], 8'h18);

        // Frame start on word 10 of an open frame
        last_run = 0; err_base = act_err; hdr_base = hdr_count;
        send_frame(10, 64'h0);
        send_frame(WORDS, 64'h0);
        drain("resync");
        check("resync_err_pulses", act_err - err_base, 1);
        check("resync_hdrs", hdr_count - hdr_base, 2);
        check("resync_run_len", last_run, 282);
        check("resync_bytes", data_bytes_seen, 200);
        check("resync_byte8", seen_data[8], 8'h01);

        // Reset during byte 5 of word 7, FIFO full
        err_base = act_err; hdr_base = hdr_count; sent_done = 0;
        fork
            send_frame(15, 64'h0);
            begin : rst_ctl
                int n;
                n = 0;
                while (!(hdr_count > hdr_base && data_bytes_seen >= 61) && n < 1000) begin
                    @(posedge clk); #1; n++;
                end
                check("midrst_reach_word7", n < 1000, 1'b1);
                check("midrst_full_before", stopin, 1'b1);
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("midrst_ctl", out_ctl, 1'b1);
                check("midrst_data", out_data, 8'h00);
                check("midrst_stopin", stopin, 1'b0);
                @(posedge clk); #1;
                reset = 1'b0;
            end
        join
        drain("midrst");
        check("midrst_orphan_errs", act_err - err_base, 3);

        last_run = 0; hdr_base = hdr_count;
        send_frame(WORDS, 64'h8080808080808080);
        drain("postrst");
        check("postrst_hdr_latency", hdr_cyc - first_acc_cyc, 2);
        check("postrst_run_len", last_run, 201);
        check("postrst_byte0", seen_data[0], 8'h80);
        check("postrst_byte199", seen_data[199], 8'h98);

        // Full FIFO with a coincident pop: the push must wait one edge
        last_run = 0; sent_done = 0;
        out_stop = 1'b1;
        fork
            send_frame(WORDS, 64'h0);
            begin : full_ctl
                int n;
                n = 0;
                while (!stopin && n < 100) begin @(posedge clk); #1; n++; end
                check("full_reached", n < 100, 1'b1);
                check("full_sent", sent_done, DEPTH);
                repeat (3) begin @(posedge clk); #1; end
                check("full_no_overflow", sent_done, DEPTH);
                check("full_stopin_held", stopin, 1'b1);
                out_stop = 1'b0;
                @(posedge clk); #1;
                check("full_pop_push_rejected", sent_done, DEPTH);
                check("full_stopin_released", stopin, 1'b0);
                @(posedge clk); #1;
                check("full_next_accepted", sent_done, DEPTH + 1);
            end
        join
        drain("full");
        check("full_run_len", last_run, 201);
        check("full_byte199", seen_data[199], 8'h18);

        check("final_queue_empty", exp_q.size(), 0);
        check("final_err_count", act_err, exp_err);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
